// File: rtl/pipeline_mem_stage.sv
// Memory stage between execute and writeback: byte-laned load/store with load alignment,
// sign/zero extension and an access timeout. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module pipeline_mem_stage #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     ex_res,
    input  logic [DATA_WIDTH-1:0]     r2_val,
    input  logic [4:0]                dst_reg,
    input  logic                      is_load,
    input  logic                      is_store,
    input  logic [1:0]                size,
    input  logic                      is_unsigned,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    input  logic                      mem_resp,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      wb_enable,
    output logic [4:0]                wb_dst_reg,
    output logic [DATA_WIDTH-1:0]     wb_dst_val,
    output logic                      mem_err
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);
    localparam int BW = OW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         ctr_q, ctr_d;

    logic                  mem_req_d, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;
    logic [NB-1:0]         mem_wstrb_d;
    logic                  wb_enable_d, mem_err_d;
    logic [4:0]            wb_dst_reg_d;
    logic [DATA_WIDTH-1:0] wb_dst_val_d;

    logic                  acc_load_q, acc_load_d;
    logic [OW-1:0]         acc_off_q, acc_off_d;
    logic [BW-1:0]         acc_bytes_q, acc_bytes_d;
    logic                  acc_uns_q, acc_uns_d;
    logic [4:0]            acc_dst_q, acc_dst_d;

    logic                  accept;
    logic                  req_is_mem;
    logic [OW-1:0]         req_off;
    logic [BW-1:0]         req_bytes;
    logic                  req_misaligned;
    logic [NB-1:0]         req_strb;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] load_val;

    // Access width in bytes, clamped to the bus width.
    function automatic logic [BW-1:0] lane_bytes(input logic [1:0] sz);
        logic [BW+2:0] raw;
        raw = (BW+3)'(1) << sz;
        return (raw > (BW+3)'(NB)) ? BW'(NB) : raw[BW-1:0];
    endfunction

    // Lanes off..off+nbytes-1; anything past lane NB-1 simply falls off the bus.
    function automatic logic [NB-1:0] lane_strobe(input logic [OW-1:0] off,
                                                  input logic [BW-1:0] nbytes);
        logic [NB-1:0] s;
        logic [BW:0]   lo;
        logic [BW:0]   hi;
        lo = (BW+1)'(off);
        hi = lo + (BW+1)'(nbytes);
        s  = '0;
        for (int i = 0; i < NB; i++) begin
            s[i] = ((BW+1)'(i) >= lo) && ((BW+1)'(i) < hi);
        end
        return s;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_align(input logic [DATA_WIDTH-1:0] raw,
                                                         input logic [OW-1:0]         off,
                                                         input logic [BW-1:0]         nbytes,
                                                         input logic                  uns);
        logic [DATA_WIDTH-1:0] shifted;
        logic [DATA_WIDTH-1:0] res;
        logic                  sign;
        shifted = raw >> {off, 3'b000};
        sign    = 1'b0;
        res     = '0;
        for (int i = 0; i < NB; i++) begin
            if (BW'(i + 1) == nbytes) begin
                sign = shifted[8*i+7];
            end
        end
        for (int i = 0; i < NB; i++) begin
            res[8*i +: 8] = (BW'(i) < nbytes) ? shifted[8*i +: 8] : {8{sign & ~uns}};
        end
        return res;
    endfunction

    assign in_ready       = (state_q == IDLE) & reset;
    assign accept         = in_valid & in_ready;
    assign req_is_mem     = is_load | is_store;
    assign req_off        = ex_res[OW-1:0];
    assign req_bytes      = lane_bytes(size);
    assign req_misaligned = (BW'(req_off) & (req_bytes - BW'(1))) != '0;
    assign req_strb       = lane_strobe(req_off, req_bytes);
    assign req_wdata      = r2_val << {req_off, 3'b000};
    assign req_addr       = {ex_res[ADDR_WIDTH-1:OW], {OW{1'b0}}};
    assign load_val       = load_align(mem_rdata, acc_off_q, acc_bytes_q, acc_uns_q);

    // Next-state and output decode; response beats the timeout when both land together.
    always_comb begin
        state_d      = state_q;
        ctr_d        = ctr_q;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_wstrb_d  = mem_wstrb;
        wb_enable_d  = 1'b0;
        mem_err_d    = 1'b0;
        wb_dst_reg_d = wb_dst_reg;
        wb_dst_val_d = wb_dst_val;
        acc_load_d   = acc_load_q;
        acc_off_d    = acc_off_q;
        acc_bytes_d  = acc_bytes_q;
        acc_uns_d    = acc_uns_q;
        acc_dst_d    = acc_dst_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!req_is_mem) begin
                        wb_enable_d  = (dst_reg != 5'd0);
                        wb_dst_reg_d = dst_reg;
                        wb_dst_val_d = ex_res;
                    end else if (TRAP_EN && req_misaligned) begin
                        mem_err_d = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        ctr_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ~is_load;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                        mem_wstrb_d = req_strb;
                        acc_load_d  = is_load;
                        acc_off_d   = req_off;
                        acc_bytes_d = req_bytes;
                        acc_uns_d   = is_unsigned;
                        acc_dst_d   = dst_reg;
                    end
                end
            end
            ACCESS: begin
                if (mem_resp) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (acc_load_q) begin
                        wb_enable_d  = (acc_dst_q != 5'd0);
                        wb_dst_reg_d = acc_dst_q;
                        wb_dst_val_d = load_val;
                    end
                end else if (ctr_q == CW'(TIMEOUT)) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Async reset drops an in-flight request immediately and forgets the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ctr_q       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            wb_enable   <= 1'b0;
            wb_dst_reg  <= '0;
            wb_dst_val  <= '0;
            mem_err     <= 1'b0;
            acc_load_q  <= 1'b0;
            acc_off_q   <= '0;
            acc_bytes_q <= '0;
            acc_uns_q   <= 1'b0;
            acc_dst_q   <= '0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            mem_wstrb   <= mem_wstrb_d;
            wb_enable   <= wb_enable_d;
            wb_dst_reg  <= wb_dst_reg_d;
            wb_dst_val  <= wb_dst_val_d;
            mem_err     <= mem_err_d;
            acc_load_q  <= acc_load_d;
            acc_off_q   <= acc_off_d;
            acc_bytes_q <= acc_bytes_d;
            acc_uns_q   <= acc_uns_d;
            acc_dst_q   <= acc_dst_d;
        end
    end

endmodule
